hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the execute stage of the pipelined ARM core. It tracks destination registers of in-flight instructions through Memory and Writeback, and drives the execute-stage operand forwarding selects (forwardAE/forwardBE). It also generates stall/flush controls for Fetch, Decode and Execute, covering load-use, PC-write, taken-branch and multicycle-multiply hazards.

## Interface

Parameters:
- MUL_CYCLES, 4, execute-stage occupancy of a multiply in cycles (legal range 2..16)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- RA1D, RA2D  in  4 each  Decode-stage source register addresses
- RA1E, RA2E  in  4 each  Execute-stage source register addresses
- RdE  in  4  Execute-stage destination register
- RegWriteE, MemtoRegE, PCSrcE  in  1 each  Execute-stage control bits, already condition-qualified
- PCSrcD  in  1  Decode-stage instruction writes PC
- BranchTakenE  in  1  taken branch resolved in Execute
- MulStartE  in  1  multiply entering Execute this cycle
- forwardAE, forwardBE  out  2 each  operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  out  1 each  hold Fetch PC / Decode / Execute pipeline registers
- FlushD, FlushE  out  1 each  clear Decode / Execute pipeline registers next edge
- MulBusy  out  1  multiply occupying Execute

## Operation

- Tracking registers: RdM, RegWriteM, MemtoRegM, PCSrcM are loaded from the E inputs. RdW, RegWriteW, PCSrcW are loaded from the M copies. All update every cycle.
- Bubble insertion: while StallE=1, the M copies load RegWriteM=MemtoRegM=PCSrcM=0.
- Forwarding, per operand X in {A,B}:
  - 10 if RegWriteM and RdM==RAXE and RAXE!=15.
  - Otherwise 01 if RegWriteW and RdW==RAXE and RAXE!=15.
  - Otherwise 00.
  - M has priority over W. R15 is never forwarded.
- ldrStall = MemtoRegE & RegWriteE & (RdE==RA1D | RdE==RA2D).
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- Multiply counter, states IDLE and BUSY:
  - IDLE→BUSY on MulStartE & ~BranchTakenE. The counter loads MUL_CYCLES-1.
  - In BUSY, the counter decrements each cycle. BUSY→IDLE when it reaches 1, giving exactly MUL_CYCLES-1 busy cycles.
  - MulBusy = (state==BUSY).
  - MulStartE while BUSY is ignored.
- Output equations:
  - StallE = MulBusy.
  - StallD = ldrStall | MulBusy.
  - StallF = ldrStall | PCWrPending | MulBusy.
  - FlushE = (ldrStall | BranchTakenE) & ~MulBusy.
  - FlushD = (PCWrPending | BranchTakenE) & ~StallD.
- Simultaneous events:
  - BranchTakenE with MulStartE: the branch wins, and no multiply starts.
  - ldrStall with BranchTakenE: FlushD=1 and FlushE=1. StallD still asserts, so Decode holds the squashed slot; FlushD is not asserted on a stall cycle. BranchTakenE overrides this masking. Use FlushD = BranchTakenE | (PCWrPending & ~StallD).

## Timing

- Forward selects, stalls and flushes are combinational from inputs and tracking registers, valid in the same cycle.
- State is updated on the rising edge of clk.
- Tracking latency: an E-stage write becomes the M source 1 cycle later and the W source 2 cycles later.
- Reset (reset==0 at an edge):
  - All tracking registers clear to 0. The counter clears to 0 and the state goes to IDLE.
  - With idle inputs, all outputs read 0 and forward selects read 00.
- Reset asserted mid-multiply: MulBusy drops on the same edge. No stall is held afterwards.
- Reset asserted mid-pending PC write: PCSrcM/W are cleared, so StallF depends only on the D/E inputs afterwards.

## Structure

- Shared package hazard_pkg, holding:
  - enum fwd_sel_t: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Constant PC_REG=4'd15.
  - MUL_CNT_W = $clog2(16).
- One sub-module, mul_occupancy: IDLE/BUSY FSM plus down-counter, with inputs start/kill and output busy.
- Everything else is flat in hazard_ctrl.

## Test plan

- Forward from M: RdE=3 and RegWriteE=1 in cycle 0, then RA1E=3 in cycle 1 → forwardAE=10, forwardBE=00. If RA2E=3 in cycle 2 with no newer writer → forwardBE=01.
- M priority and R15:
  - RdM=RdW=5, both writing, RA1E=5 → forwardAE=10.
  - RdM=15 writing, RA2E=15 → forwardBE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, RdE=2, RA2D=2 → StallF=StallD=FlushE=1 for one cycle, FlushD=0. The next cycle has RegWriteM=1, RdM=2, and forward 10 is available.
- Branch: BranchTakenE=1 → FlushD=FlushE=1 in the same cycle. PCSrcE=1 → StallF=1 and FlushD=1 while PCSrcE or PCSrcM is high (2 cycles).
- Multiply, MUL_CYCLES=4: MulStartE pulse → MulBusy=1 for exactly 3 cycles, with StallF/D/E=1 and the M tracking bubbled. A second MulStartE during busy is ignored. MulStartE together with BranchTakenE → MulBusy stays 0.
- Reset: assert reset=0 during BUSY and with a pending PC write → next cycle all outputs 0 and forward selects 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W     = 4;
    localparam int unsigned MUL_CNT_W = $clog2(16);

    localparam logic [REG_W-1:0] PC_REG = 4'd15;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    // Destination tracking payload carried down the M and W stages
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } trk_t;

    // M beats W; R15 reads the architectural PC and is never forwarded
    function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] ra,
                                         input trk_t              m,
                                         input trk_t              w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra != PC_REG) begin
            if (m.reg_write && (m.rd == ra)) begin
                sel = FWD_M;
            end else if (w.reg_write && (w.rd == ra)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mul_occupancy.sv
// Tracks how long a multiply occupies Execute: IDLE/BUSY FSM with a down-counter.
module mul_occupancy
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic kill,
    output logic busy
);

    mul_state_t           r_state;
    mul_state_t           w_state_nxt;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [MUL_CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= MUL_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter holds remaining busy cycles; a killed start never enters BUSY
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MUL_IDLE: begin
                if (start && !kill) begin
                    w_state_nxt = MUL_BUSY;
                    w_cnt_nxt   = MUL_CNT_W'(MUL_CYCLES - 1);
                end
            end
            MUL_BUSY: begin
                w_cnt_nxt = r_cnt - MUL_CNT_W'(1);
                if (r_cnt == MUL_CNT_W'(1)) begin
                    w_state_nxt = MUL_IDLE;
                end
            end
            default: begin
                w_state_nxt = MUL_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == MUL_BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding selects plus
// stall/flush generation for load-use, PC-write, branch and multiply hazards.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] RdE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             PCSrcE,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    input  logic             MulStartE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MulBusy
);

    trk_t r_m;
    trk_t r_w;
    logic r_pcsrc_m;
    logic w_mul_busy;
    logic w_ldr_stall;
    logic w_pc_wr_pending;
    logic w_stall_d;

    mul_occupancy #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_occupancy (
        .clk   (clk),
        .reset (reset),
        .start (MulStartE),
        .kill  (BranchTakenE),
        .busy  (w_mul_busy)
    );

    // MemtoReg and PCSrc feed no hazard past M, so only the bits that are read are kept
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m       <= '0;
            r_w       <= '0;
            r_pcsrc_m <= 1'b0;
        end else begin
            r_m.rd        <= RdE;
            r_m.reg_write <= RegWriteE & ~w_mul_busy;
            r_pcsrc_m     <= PCSrcE & ~w_mul_busy;
            r_w           <= r_m;
        end
    end

    always_comb begin
        w_ldr_stall     = MemtoRegE & RegWriteE & ((RdE == RA1D) | (RdE == RA2D));
        w_pc_wr_pending = PCSrcD | PCSrcE | r_pcsrc_m;
        w_stall_d       = w_ldr_stall | w_mul_busy;
    end

    // A taken branch squashes Decode even while Decode is held by a stall
    always_comb begin
        forwardAE = fwd_sel(RA1E, r_m, r_w);
        forwardBE = fwd_sel(RA2E, r_m, r_w);
        MulBusy   = w_mul_busy;
        StallE    = w_mul_busy;
        StallD    = w_stall_d;
        StallF    = w_ldr_stall | w_pc_wr_pending | w_mul_busy;
        FlushE    = (w_ldr_stall | BranchTakenE) & ~w_mul_busy;
        FlushD    = BranchTakenE | (w_pc_wr_pending & ~w_stall_d);
    end

endmodule
